instr_encoder_loader: RTL and testbench

//  Inverse of the instruction decoder: accepts decoded instruction fields over a valid/ready handshake.

---
 rtl/instr_encoder_loader.sv | 119 +++++++++++
 tb/tb_instr_encoder_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 32-bit words, buffers them in a small FIFO
// and streams them into instruction memory at sequential addresses.
module instr_encoder_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_imm_type,
  input  logic [2:0]        in_opsel,
  input  logic              in_mode,
  input  logic [5:0]        in_rs,
  input  logic [5:0]        in_rt,
  input  logic [5:0]        in_rd,
  input  logic [14:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err_pulse,
  output logic [7:0]        err_count,
  output logic [15:0]       words_done,
  output logic              wrapped
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  typedef struct packed {
    logic        imm_type;
    logic [2:0]  opsel;
    logic        mode;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [5:0]  rd;
    logic [14:0] imm;
  } req_t;

  req_t req;
  assign req = '{imm_type: in_imm_type, opsel: in_opsel, mode: in_mode,
                 rs: in_rs, rt: in_rt, rd: in_rd, imm: in_imm};

  // rd[5] is carried implicitly by mode; bit 16 doubles as the immediate-format flag.
  function automatic logic [31:0] encode(input req_t r);
    logic [31:0] w;
    w        = '0;
    w[0]     = r.imm_type;
    w[6:1]   = r.rs;
    w[11:7]  = r.rd[4:0];
    w[12]    = r.mode;
    w[15:13] = r.opsel;
    if (r.imm_type) begin
      w[16]    = 1'b1;
      w[31:17] = r.imm;
    end else begin
      w[23:18] = r.rt;
    end
    return w;
  endfunction

  logic [31:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          accept, conflict, push, pop;

  assign in_ready  = (count < DEPTH_C);
  assign mem_we    = (count != '0);
  assign mem_wdata = mem_we ? fifo[rd_ptr] : 32'h0;
  assign accept    = in_valid & in_ready;
  assign conflict  = in_rd[5] != in_mode;
  assign push      = accept & ~conflict & ~clear;
  assign pop       = mem_we & mem_ready & ~clear;

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= encode(req);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      mem_addr   <= BASE_C;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      words_done <= '0;
      wrapped    <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      mem_addr   <= BASE_C;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      words_done <= '0;
      wrapped    <= 1'b0;
    end else begin
      err_pulse <= accept & conflict;
      if (accept && conflict && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        mem_addr <= mem_addr + ADDR_W'(1);
        if (mem_addr == '1) wrapped <= 1'b1;
        if (words_done != 16'hFFFF) words_done <= words_done + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding, conflict drop, backpressure,
// address wrap (narrow instance), clear and asynchronous reset.
module tb_instr_encoder_loader;
  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, mem_ready;
  logic        in_imm_type, in_mode;
  logic [2:0]  in_opsel;
  logic [5:0]  in_rs, in_rt, in_rd;
  logic [14:0] in_imm;

  logic        in_ready, mem_we, err_pulse, wrapped;
  logic [7:0]  mem_addr, err_count;
  logic [31:0] mem_wdata;
  logic [15:0] words_done;

  logic        n_in_ready, n_mem_we, n_err_pulse, n_wrapped;
  logic [1:0]  n_mem_addr;
  logic [7:0]  n_err_count;
  logic [31:0] n_mem_wdata;
  logic [15:0] n_words_done;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.FIFO_DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm_type(in_imm_type), .in_opsel(in_opsel), .in_mode(in_mode), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .err_pulse(err_pulse),
    .err_count(err_count), .words_done(words_done), .wrapped(wrapped));

  instr_encoder_loader #(.FIFO_DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_imm_type(in_imm_type), .in_opsel(in_opsel), .in_mode(in_mode), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .mem_we(n_mem_we), .mem_ready(mem_ready),
    .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata), .err_pulse(n_err_pulse),
    .err_count(n_err_count), .words_done(n_words_done), .wrapped(n_wrapped));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic beat(input logic it, input logic [2:0] op, input logic md,
                      input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] rd,
                      input logic [14:0] imm);
    in_valid = 1'b1; in_imm_type = it; in_opsel = op; in_mode = md;
    in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_imm_type = 1'b0; in_opsel = '0; in_mode = 1'b0;
    in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  logic [1:0] wrap_exp [5];

  initial begin
    rst_n = 1'b0; clear = 1'b0; mem_ready = 1'b1;
    idle();
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_words_done", words_done, 0);
    chk("rst_wrapped", wrapped, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // register-type encoding
    beat(1'b0, 3'b001, 1'b0, 6'd3, 6'd9, 6'd5, 15'h0);
    @(negedge clk); idle();
    chk("reg_we", mem_we, 1);
    chk("reg_addr", mem_addr, 0);
    chk("reg_wdata", mem_wdata, 32'h00242286);
    @(negedge clk);
    chk("reg_popped", mem_we, 0);
    chk("reg_addr_inc", mem_addr, 1);
    chk("reg_done", words_done, 1);

    // immediate-type encoding
    beat(1'b1, 3'b010, 1'b1, 6'd1, 6'd0, 6'd33, 15'h7FFF);
    @(negedge clk); idle();
    chk("imm_we", mem_we, 1);
    chk("imm_addr", mem_addr, 1);
    chk("imm_wdata", mem_wdata, 32'hFFFF5083);
    @(negedge clk);
    chk("imm_done", words_done, 2);

    // field conflict: accepted but dropped
    beat(1'b0, 3'b000, 1'b0, 6'd0, 6'd0, 6'd33, 15'h0);
    @(negedge clk); idle();
    chk("cfl_we", mem_we, 0);
    chk("cfl_pulse", err_pulse, 1);
    chk("cfl_count", err_count, 1);
    @(negedge clk);
    chk("cfl_pulse_end", err_pulse, 0);

    // clear resets address and counters
    do_clear();
    chk("clr_addr", mem_addr, 0);
    chk("clr_done", words_done, 0);
    chk("clr_err", err_count, 0);

    // backpressure: 5 beats offered, 4 accepted
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      beat(1'b0, 3'b000, 1'b0, 6'd0, 6'(k + 1), 6'd0, 15'h0);
      @(negedge clk);
    end
    chk("bp_ready", in_ready, 0);
    chk("bp_we", mem_we, 1);
    chk("bp_hold", mem_wdata, 32'h00040000);
    idle();
    @(negedge clk);
    chk("bp_hold2", mem_wdata, 32'h00040000);
    chk("bp_addr_hold", mem_addr, 0);
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_addr%0d", k), mem_addr, k);
      chk($sformatf("bp_wdata%0d", k), mem_wdata, (k + 1) << 18);
      @(negedge clk);
    end
    chk("bp_drained", mem_we, 0);
    chk("bp_done", words_done, 4);

    // address wrap on the 2-bit instance
    do_clear();
    wrap_exp[0] = 2'd0; wrap_exp[1] = 2'd1; wrap_exp[2] = 2'd2;
    wrap_exp[3] = 2'd3; wrap_exp[4] = 2'd0;
    for (int k = 0; k < 5; k++) begin
      beat(1'b0, 3'b000, 1'b0, 6'd0, 6'd1, 6'd0, 15'h0);
      @(negedge clk); idle();
      chk($sformatf("wrap_we%0d", k), n_mem_we, 1);
      chk($sformatf("wrap_addr%0d", k), n_mem_addr, wrap_exp[k]);
      @(negedge clk);
    end
    chk("wrap_set", n_wrapped, 1);
    chk("wide_nowrap", wrapped, 0);
    chk("wide_addr", mem_addr, 5);
    do_clear();
    chk("wrap_clr_addr", n_mem_addr, 0);
    chk("wrap_clr_flag", n_wrapped, 0);

    // async reset while stalled
    mem_ready = 1'b0;
    beat(1'b0, 3'b000, 1'b1, 6'd0, 6'd0, 6'd0, 15'h0);
    @(negedge clk);
    beat(1'b0, 3'b011, 1'b0, 6'd2, 6'd4, 6'd6, 15'h0);
    @(negedge clk);
    beat(1'b0, 3'b011, 1'b0, 6'd2, 6'd4, 6'd7, 15'h0);
    @(negedge clk); idle();
    chk("stall_we", mem_we, 1);
    chk("stall_err", err_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_err", err_count, 0);
    chk("arst_done", words_done, 0);
    chk("arst_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", mem_we, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
